// File: rtl/lbb_dma_pkg.sv
// Shared types and helpers for the LBB DMA request arbiter: FSM state encoding,
// request-pin bit positions and the round-robin pointer advance.
package lbb_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_REQ,
    ST_XFER,
    ST_RELEASE
  } dma_state_e;

  localparam int REQ_BIT  = 0;
  localparam int LAST_BIT = 1;

  function automatic int rr_next(input int ch, input int nch);
    return (ch >= nch - 1) ? 0 : ch + 1;
  endfunction

endpackage

// File: rtl/lbb_rr_arb.sv
// NCH-wide round-robin picker: first active-low request at or after the
// registered pointer, modulo NCH. Pointer moves past a channel on adv_i.
module lbb_rr_arb
  import lbb_dma_pkg::*;
#(
  parameter int NCH = 5,
  parameter int CHW = 3
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [NCH-1:0] req_n_i,
  input  logic           adv_i,
  input  logic [CHW-1:0] adv_ch_i,
  output logic           any_o,
  output logic [CHW-1:0] pick_o
);

  logic [CHW-1:0]   ptr_q, ptr_d;
  logic [2*NCH-1:0] req_rot;
  logic [CHW:0]     off;
  logic [CHW:0]     sum;

  // Doubling the vector turns the modulo scan into a plain shift.
  assign req_rot = {~req_n_i, ~req_n_i} >> ptr_q;

  always_comb begin
    any_o = 1'b0;
    off   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!any_o && req_rot[i]) begin
        any_o = 1'b1;
        off   = (CHW+1)'(i);
      end
    end
  end

  assign sum    = {1'b0, ptr_q} + off;
  assign pick_o = (sum >= (CHW+1)'(NCH)) ? CHW'(sum - (CHW+1)'(NCH)) : CHW'(sum);

  assign ptr_d = adv_i ? CHW'(rr_next(int'(adv_ch_i), NCH)) : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lbb_dma_req_arb.sv
// TCI-to-i960 DMA request arbiter and burst controller (round robin, word
// counting, EOT). Optional REQ watchdog: define LBB_DMA_WATCHDOG_EN.
module lbb_dma_req_arb
  import lbb_dma_pkg::*;
#(
  parameter int NCH       = 5,
  parameter int CHW       = 3,
  parameter int BURST_MAX = 8,
  parameter int CNT_W     = 4,
  parameter int TMO_CYC   = 255
) (
  input  logic             I_LCLK,
  input  logic             IN_RESET,
  input  logic [2*NCH-1:0] IN_TCI_DMA_REQ,
  input  logic             IN_DACK,
  input  logic             IN_READYo,
  output logic             ON_DREQ,
  output logic             ON_EOT,
  output logic [NCH-1:0]   ON_TCI_BLOCK_SEL,
  output logic             O_GNT_VALID,
  output logic [CHW-1:0]   O_GNT_CH,
  output logic [CNT_W-1:0] O_WORD_CNT,
  output logic             O_TMO_ERR
);

  if (NCH < 2 || NCH > 16 || (2**CHW) < NCH || BURST_MAX < 1 ||
      BURST_MAX >= (2**CNT_W) || TMO_CYC < 1) begin : g_cfg_err
    $error("lbb_dma_req_arb: illegal parameter set");
  end

  logic [2*NCH-1:0] req_meta_q, req_sync_q;
  dma_state_e       state_q, state_d;
  logic [CHW-1:0]   gnt_ch_q, gnt_ch_d;
  logic             last_q, last_d;
  logic [NCH-1:0]   sel_q, sel_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [NCH-1:0]   req_n, last_n, pick_oh;
  logic             any_req, adv, eot, word;
  logic [CHW-1:0]   pick;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign req_n[c]  = req_sync_q[2*c + REQ_BIT];
    assign last_n[c] = req_sync_q[2*c + LAST_BIT];
  end

  lbb_rr_arb #(.NCH(NCH), .CHW(CHW)) u_rr (
    .clk_i   (I_LCLK),
    .rst_ni  (IN_RESET),
    .req_n_i (req_n),
    .adv_i   (adv),
    .adv_ch_i(gnt_ch_q),
    .any_o   (any_req),
    .pick_o  (pick)
  );

  assign pick_oh = NCH'(1) << pick;
  assign word    = ~IN_DACK & ~IN_READYo;
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

`ifdef LBB_DMA_WATCHDOG_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_ch_d = gnt_ch_q;
    last_d   = last_q;
    sel_d    = sel_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    adv      = 1'b0;
    eot      = 1'b0;
`ifdef LBB_DMA_WATCHDOG_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d  = ST_GRANT;
          gnt_ch_d = pick;
          last_d   = |(~last_n & pick_oh);
          sel_d    = ~pick_oh;
          vld_d    = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_GRANT: state_d = ST_REQ;
      ST_REQ: begin
        if (!IN_DACK) state_d = ST_XFER;
`ifdef LBB_DMA_WATCHDOG_EN
        else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          state_d = ST_RELEASE;
          err_d   = 1'b1;
        end
`endif
      end
      ST_XFER: begin
        if (word) begin
          if (cnt_q != CNT_W'(BURST_MAX)) cnt_d = cnt_inc[CNT_W-1:0];
          if (cnt_inc == (CNT_W+1)'(BURST_MAX) || last_q) begin
            eot     = 1'b1;
            state_d = ST_RELEASE;
          end
        end else if (IN_DACK) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Drop the grant on entry so RELEASE already shows it released.
    if (state_d == ST_RELEASE && state_q != ST_RELEASE) begin
      sel_d = '1;
      vld_d = 1'b0;
      adv   = 1'b1;
    end
  end

  always_ff @(posedge I_LCLK or negedge IN_RESET) begin
    if (!IN_RESET) begin
      req_meta_q <= '1;
      req_sync_q <= '1;
      state_q    <= ST_IDLE;
      gnt_ch_q   <= '0;
      last_q     <= 1'b0;
      sel_q      <= '1;
      vld_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      req_meta_q <= IN_TCI_DMA_REQ;
      req_sync_q <= req_meta_q;
      state_q    <= state_d;
      gnt_ch_q   <= gnt_ch_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      vld_q      <= vld_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef LBB_DMA_WATCHDOG_EN
  assign tmo_d = (state_q == ST_REQ) ? tmo_q + 1'b1 : '0;

  always_ff @(posedge I_LCLK or negedge IN_RESET) begin
    if (!IN_RESET) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign O_TMO_ERR = err_q;
`else
  assign O_TMO_ERR = 1'b0;
`endif

  assign ON_DREQ          = ~(state_q == ST_REQ || state_q == ST_XFER);
  assign ON_EOT           = ~eot;
  assign ON_TCI_BLOCK_SEL = sel_q;
  assign O_GNT_VALID      = vld_q;
  assign O_GNT_CH         = gnt_ch_q;
  assign O_WORD_CNT       = cnt_q;

endmodule
